booth_pp_acc: RTL
=================

BOOTH_PP_ACC -- requirements
Module: booth_pp_acc

Interface
REQ-001 SHALL have parameter NDIG, default 8, meaning the number of radix-4 digits per operation (16-bit multiplier).
REQ-002 SHALL have parameter W, default 16, meaning the multiplicand width; product width is 2*W.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 mcand  input  W  two's-complement multiplicand, captured on an accepted start.
REQ-007 dig_valid  input  1  Booth digit present on neg/zero/one/two.
REQ-008 neg  input  1  digit sign (1 = negative).
REQ-009 zero  input  1  digit magnitude is 0.
REQ-010 one  input  1  digit magnitude is 1.
REQ-011 two  input  1  digit magnitude is 2.
REQ-012 dig_ready  output  1  block accepts a digit this cycle.
REQ-013 busy  output  1  operation in progress (not IDLE).
REQ-014 done  output  1  one-cycle pulse: prod holds a new result.
REQ-015 prod  output  2*W  two's-complement product.
REQ-016 err  output  1  sticky flag: an illegal digit was accepted in the current or last operation.

Function
REQ-017 SHALL implement states IDLE, RUN, FIN.
REQ-018 IDLE: start=1 -> latch mcand, clear accumulator, digit index idx=0, clear err, go to RUN next cycle.
REQ-019 start while in RUN or FIN SHALL be ignored.
REQ-020 dig_ready SHALL be 1 only in RUN; a digit is accepted when dig_valid and dig_ready are both 1.
REQ-021 Accepted digit SHALL be decoded as mag = 0 if zero, mcand if one, mcand<<1 if two.
REQ-022 Partial product pp = neg ? -mag : mag, sign-extended to 2*W bits before negation, then shifted left by 2*idx.
REQ-023 neg with zero (code 111) SHALL contribute 0.
REQ-024 Each accepted digit SHALL add pp to the 2*W-bit accumulator (modulo 2^(2*W); no overflow flag) and increment idx.
REQ-025 Cycles in RUN with dig_valid=0 SHALL leave all state unchanged; no timeout.
REQ-026 Acceptance of digit idx=NDIG-1 SHALL move to FIN; the final sum SHALL be loaded into prod on that same edge.
REQ-027 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 Latency: with dig_valid held high, done is asserted NDIG+1 cycles after the start-accepting edge.
REQ-029 prod SHALL hold its value until the next FIN; it SHALL NOT change during RUN.
REQ-030 Illegal digit (zero+one+two not exactly one set) SHALL be treated as magnitude 0, SHALL still advance idx, and SHALL set err.
REQ-031 err SHALL stay set until the next accepted start or reset.
REQ-032 busy SHALL be 1 in RUN and FIN.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, prod=0, done=0, err=0, busy=0, dig_ready=0, idx=0, accumulator=0.
REQ-034 Reset during RUN SHALL abandon the operation; no done pulse follows; the next start runs a clean operation.
REQ-035 Reset release SHALL take effect synchronously at the next clk edge with no spurious done.

Verification
REQ-036 mcand=3; digits (LSB first) +1,+1,0,0,0,0,0,0 (multiplier 5), continuous valid -> prod=0x0000000F, done exactly 9 cycles after start.
REQ-037 mcand=1234; digits -1 then 7x zero with neg=1 (multiplier -1) -> prod=0xFFFFFB2E, err=0.
REQ-038 mcand=0x8000; digits 7x zero then -2 (multiplier 0x8000) -> prod=0x40000000.
REQ-039 Same as REQ-036 with dig_valid gaps of 1-3 cycles and start pulses during RUN -> identical prod, single done, starts ignored.
REQ-040 One digit with one=1 and two=1 -> err=1 and the digit contributes 0; err clears on the next start.
REQ-041 rst_n low after 4 accepted digits -> all outputs zero; a fresh REQ-036 run then yields 0x0000000F.

Source files
------------

// File: rtl/booth_pp_acc.sv
// Radix-4 Booth partial-product accumulator.
// Takes one pre-decoded Booth digit per cycle (LSB digit first), forms the
// partial product from the latched multiplicand and sums it into a 2*W-bit
// accumulator. After NDIG digits the sum is published on prod with a done pulse.
module booth_pp_acc #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic           dig_valid,
  input  logic           neg,
  input  logic           zero,
  input  logic           one,
  input  logic           two,
  output logic           dig_ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod,
  output logic           err
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;

  logic [PW-1:0]   mcand_ext;
  logic [PW-1:0]   mag;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   pp_shifted;
  logic [PW-1:0]   acc_sum;
  logic            legal;

  // Partial product for the digit currently on the inputs, and the running sum.
  always_comb begin
    mcand_ext = {{W{mcand_q[W-1]}}, mcand_q};
    // Exactly one magnitude line must be set; anything else counts as zero.
    legal     = (zero ^ one ^ two) & ~(zero & one & two);
    mag       = '0;
    if (legal && one) begin
      mag = mcand_ext;
    end else if (legal && two) begin
      mag = mcand_ext << 1;
    end
    // Negating a zero magnitude yields zero, so code 111 contributes nothing.
    pp         = neg ? -mag : mag;
    pp_shifted = pp << {idx_q, 1'b0};
    acc_sum    = acc_q + pp_shifted;
  end

  // Next-state logic: operation sequencing and accumulator update.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    prod_d  = prod_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = mcand;
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (dig_valid) begin
          acc_d = acc_sum;
          idx_d = idx_q + IW'(1);
          if (!legal) begin
            err_d = 1'b1;
          end
          if (idx_q == LastIdx) begin
            prod_d  = acc_sum;
            idx_d   = '0;
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    dig_ready = (state_q == StRun);
    busy      = (state_q != StIdle);
    done      = (state_q == StFin);
    prod      = prod_q;
    err       = err_q;
  end

endmodule
